disp_scan_driver: RTL and testbench

Downstream consumer of the SoC general-purpose outputs. Takes the 32-bit result word and the select/error flags driven by the SoC, converts the selected value for display, and time-multiplexes it onto an 8-digit common-anode seven-segment display. Sits between the SoC GPIO outputs and the board display pins.

---
 rtl/soc_disp_pkg.sv | 30 +++
 rtl/disp_bin2bcd.sv | 86 ++++++++
 rtl/disp_scan_driver.sv | 167 ++++++++++++++++
 tb/tb_disp_scan_driver.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/soc_disp_pkg.sv
// ---------------------------------------------------------------------------
// soc_disp_pkg
// Constants shared by the display scan driver and its BCD converter:
//   - seven-segment encodings, active-low, bit order {g,f,e,d,c,b,a}
//   - digit count and converter word widths
//   - state encoding of the binary-to-BCD converter
// ---------------------------------------------------------------------------
package soc_disp_pkg;

  localparam int NDIG_C = 8;
  localparam int BIN_W  = 32;
  localparam int BCD_W  = 40;   // 10 decimal digits cover the full 32-bit range

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_R     = 7'h2F;

  // Glyphs 0-9, A, b, C, d, E, F
  localparam logic [6:0] SEG_HEX [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef enum logic [1:0] {
    CONV_IDLE  = 2'd0,
    CONV_SHIFT = 2'd1,
    CONV_DONE  = 2'd2
  } conv_state_e;

endpackage

// File: rtl/disp_bin2bcd.sv
// ---------------------------------------------------------------------------
// disp_bin2bcd
// Sequential double-dabble converter: 32 shift-add-3 iterations, one per
// clock. The first shift happens on the start edge itself, so the last shift
// lands 31 cycles later and DONE is held for exactly one cycle after that.
// Only exists in the decimal build (DISP_BCD_EN defined).
//
// Ports:
//   clk    in   system clock
//   rst    in   synchronous active-high reset
//   start  in   accept pulse; value is sampled on this edge when idle
//   value  in   32-bit binary input
//   busy   out  high from the start edge until DONE returns to IDLE
//   done   out  one-cycle strobe: bcd is final and stable
//   bcd    out  40-bit packed BCD result
// ---------------------------------------------------------------------------
`ifdef DISP_BCD_EN
module disp_bin2bcd
  import soc_disp_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [BIN_W-1:0] value,
  output logic             busy,
  output logic             done,
  output logic [BCD_W-1:0] bcd
);

  conv_state_e      state_q, state_nx;
  logic [BIN_W-1:0] bin_q;
  logic [BCD_W-1:0] bcd_q;
  logic [4:0]       cnt_q;
  logic [BCD_W-1:0] adj;

  // Add 3 to every BCD digit that is 5 or more before the next shift
  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < BCD_W / 4; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_nx = state_q;
    unique case (state_q)
      CONV_IDLE:  if (start) state_nx = CONV_SHIFT;
      CONV_SHIFT: if (cnt_q == 5'd31) state_nx = CONV_DONE;
      CONV_DONE:  state_nx = CONV_IDLE;
      default:    state_nx = CONV_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CONV_IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_nx;
      unique case (state_q)
        CONV_IDLE: begin
          if (start) begin
            // Iteration 1 needs no add-3: the BCD accumulator starts at zero
            bcd_q <= {{(BCD_W-1){1'b0}}, value[BIN_W-1]};
            bin_q <= {value[BIN_W-2:0], 1'b0};
            cnt_q <= 5'd1;
          end
        end
        CONV_SHIFT: begin
          bcd_q <= {adj[BCD_W-2:0], bin_q[BIN_W-1]};
          bin_q <= {bin_q[BIN_W-2:0], 1'b0};
          cnt_q <= cnt_q + 5'd1;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state_q != CONV_IDLE);
  assign done = (state_q == CONV_DONE);
  assign bcd  = bcd_q;

endmodule
`endif

// File: rtl/disp_scan_driver.sv
// ---------------------------------------------------------------------------
// disp_scan_driver
// Picks val_a or val_b, holds it in a shadow register, converts it for
// display and scans it onto an 8-digit common-anode seven-segment display
// with leading-zero blanking and an "Err" override.
//
// Build option DISP_BCD_EN:
//   defined   - decimal display through disp_bin2bcd; dp on digit 7 flags
//               values of 100000000 or more
//   undefined - hexadecimal display of the shadow nibbles, busy tied low,
//               dp never lit
//
// Ports:
//   clk    in   system clock
//   rst    in   synchronous active-high reset
//   val_a  in   primary value, shown when sel = 0
//   val_b  in   alternate value, shown when sel = 1
//   sel    in   source select
//   err    in   show "Err" instead of the value
//   an     out  digit enables, active-low, one-hot
//   seg    out  segments {g..a}, active-low
//   dp     out  decimal point, active-low
//   busy   out  conversion in progress
// ---------------------------------------------------------------------------
module disp_scan_driver
  import soc_disp_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int NDIG        = NDIG_C
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     val_a,
  input  logic [31:0]     val_b,
  input  logic            sel,
  input  logic            err,
  output logic [NDIG-1:0] an,
  output logic [6:0]      seg,
  output logic            dp,
  output logic            busy
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = $clog2(NDIG);

  logic [31:0]       source;
  logic [31:0]       shadow_q;
  logic              accept;
  logic              conv_busy;
  logic [4*NDIG-1:0] digits_q;
  logic              ovf;
  logic [CNT_W-1:0]  refresh_q;
  logic [IDX_W-1:0]  idx_q;
  logic [NDIG-1:0]   shown;
  logic [3:0]        cur_nib;
  logic [NDIG-1:0]   an_nx;
  logic [6:0]        seg_nx;
  logic              dp_nx;

  assign source = sel ? val_b : val_a;
  // Changes arriving mid-conversion are not queued; once busy drops the
  // compare simply sees the difference again and restarts.
  assign accept = (source != shadow_q) && !conv_busy;

  always_ff @(posedge clk) begin
    // NOTE: every clocked register uses <= so all flops sample pre-edge values
    // regardless of statement order.
    if (rst) shadow_q <= '0;
    else if (accept) shadow_q <= source;
  end

`ifdef DISP_BCD_EN
  logic             conv_done;
  logic [BCD_W-1:0] bcd;
  logic             ovf_q;

  disp_bin2bcd u_bin2bcd (
    .clk   (clk),
    .rst   (rst),
    .start (accept),
    .value (source),
    .busy  (conv_busy),
    .done  (conv_done),
    .bcd   (bcd)
  );

  // Digit registers only change when a conversion completes, so the old
  // value stays on the display while busy.
  always_ff @(posedge clk) begin
    // NOTE: the digit registers are reset (they are only 33 flops, not a RAM)
    // so an aborted conversion can never leave partial BCD on the display.
    if (rst) begin
      digits_q <= '0;
      ovf_q    <= 1'b0;
    end else if (conv_done) begin
      digits_q <= bcd[4*NDIG-1:0];
      ovf_q    <= |bcd[BCD_W-1:4*NDIG];
    end
  end

  assign ovf = ovf_q;
`else
  assign conv_busy = 1'b0;
  assign ovf       = 1'b0;

  always_ff @(posedge clk) begin
    if (rst) digits_q <= '0;
    else if (accept) digits_q <= source[4*NDIG-1:0];
  end
`endif

  // A digit is shown if it or any digit above it is non-zero; digit 0 always.
  always_comb begin
    logic lead_nz;
    // NOTE: every signal written here gets a value before any condition,
    // otherwise the missing paths would infer latches.
    lead_nz = 1'b0;
    shown   = '0;
    for (int i = NDIG - 1; i >= 0; i--) begin
      lead_nz  = lead_nz | (digits_q[4*i +: 4] != 4'd0);
      shown[i] = lead_nz;
    end
    shown[0] = 1'b1;
  end

  // Refresh counter and digit index
  always_ff @(posedge clk) begin
    if (rst) begin
      refresh_q <= '0;
      idx_q     <= '0;
    end else if (refresh_q == CNT_W'(REFRESH_DIV - 1)) begin
      refresh_q <= '0;
      idx_q     <= (idx_q == IDX_W'(NDIG - 1)) ? '0 : idx_q + 1'b1;
    end else begin
      refresh_q <= refresh_q + 1'b1;
    end
  end

  // Scan mux: pattern for the current digit index
  always_comb begin
    cur_nib = digits_q[4*idx_q +: 4];
    an_nx   = ~(NDIG'(1) << idx_q);
    seg_nx  = shown[idx_q] ? SEG_HEX[cur_nib] : SEG_BLANK;
    dp_nx   = ~(ovf && (idx_q == IDX_W'(NDIG - 1)));
    if (err) begin
      dp_nx = 1'b1;
      if (idx_q == IDX_W'(2))      seg_nx = SEG_E;
      else if (idx_q < IDX_W'(2))  seg_nx = SEG_R;
      else                         seg_nx = SEG_BLANK;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      an  <= '1;
      seg <= SEG_BLANK;
      dp  <= 1'b1;
    end else begin
      an  <= an_nx;
      seg <= seg_nx;
      dp  <= dp_nx;
    end
  end

  assign busy = conv_busy;

endmodule

// File: tb/tb_disp_scan_driver.sv
// ---------------------------------------------------------------------------
// tb_disp_scan_driver
// Directed bench for disp_scan_driver with REFRESH_DIV = 4 (one full scan is
// 32 cycles). Expected glyphs are written out by hand for both the hex build
// and the DISP_BCD_EN build. Outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_disp_scan_driver;

  localparam int DIV = 4;
`ifdef DISP_BCD_EN
  localparam bit BCD = 1'b1;
`else
  localparam bit BCD = 1'b0;
`endif
  localparam int EXP_BUSY = BCD ? 32 : 0;

  localparam logic [6:0] S0 = 7'h40, S1 = 7'h79, S2 = 7'h24, S3 = 7'h30;
  localparam logic [6:0] S4 = 7'h19, S5 = 7'h12, S6 = 7'h02, S7 = 7'h78;
  localparam logic [6:0] S8 = 7'h00, S9 = 7'h10, SB = 7'h03, SC = 7'h46;
  localparam logic [6:0] SD = 7'h21, SE = 7'h06, SF = 7'h0E;
  localparam logic [6:0] BL = 7'h7F, SR = 7'h2F;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] val_a, val_b;
  logic        sel, err;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  logic [6:0] cap_seg [8];
  logic       cap_dp  [8];
  int         cap_bad_an;
  int         cap_busy;

  always #5 clk = ~clk;

  disp_scan_driver #(.REFRESH_DIV(DIV), .NDIG(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .val_a (val_a),
    .val_b (val_b),
    .sel   (sel),
    .err   (err),
    .an    (an),
    .seg   (seg),
    .dp    (dp),
    .busy  (busy)
  );

  // Record what every digit shows over one full 32-cycle scan
  task automatic capture_scan;
    for (int i = 0; i < 8; i++) begin
      cap_seg[i] = 7'bx;
      cap_dp[i]  = 1'bx;
    end
    cap_bad_an = 0;
    cap_busy   = 0;
    for (int c = 0; c < 32; c++) begin
      @(negedge clk);
      if (busy !== 1'b0) cap_busy++;
      if ($countones(~an) != 1) cap_bad_an++;
      else begin
        for (int k = 0; k < 8; k++) begin
          if (an[k] == 1'b0) begin
            cap_seg[k] = seg;
            cap_dp[k]  = dp;
          end
        end
      end
    end
  endtask

  // Wait until a freshly accepted value reaches the output registers;
  // returns how many sampled cycles busy was high (bounded).
  task automatic settle(output int n);
    n = 0;
    if (BCD) begin
      for (int c = 0; c < 100; c++) begin
        @(negedge clk);
        if (busy === 1'b1) n++;
        else if (n > 0) break;
      end
      @(negedge clk);
    end else begin
      repeat (2) begin
        @(negedge clk);
        if (busy !== 1'b0) n++;
      end
    end
  endtask

  task automatic test_reset;
    logic [55:0] exp;
    rst = 1'b1; sel = 1'b0; err = 1'b0; val_a = '0; val_b = '0;
    repeat (2) @(negedge clk);
    checks++; if (an !== 8'hFF) begin failures++; $display("FAIL reset_an got=%h exp=FF", an); end
    checks++; if (seg !== 7'h7F) begin failures++; $display("FAIL reset_seg got=%h exp=7F", seg); end
    checks++; if (dp !== 1'b1) begin failures++; $display("FAIL reset_dp got=%b exp=1", dp); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    rst = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      checks++;
      if (an !== ((c <= 4) ? 8'hFE : 8'hFD)) begin
        failures++;
        $display("FAIL scan_timing cycle %0d an got=%h exp=%h", c, an, (c <= 4) ? 8'hFE : 8'hFD);
      end
      if (c == 1) begin
        checks++;
        if (seg !== S0) begin failures++; $display("FAIL first_digit seg got=%h exp=%h", seg, S0); end
      end
    end
    capture_scan;
    exp = {BL, BL, BL, BL, BL, BL, BL, S0};
    checks++; if (cap_bad_an != 0) begin failures++; $display("FAIL reset_onehot bad=%0d exp=0", cap_bad_an); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (cap_seg[i] !== exp[i*7 +: 7] || cap_dp[i] !== 1'b1) begin
        failures++;
        $display("FAIL reset_scan digit %0d seg=%h dp=%b exp seg=%h dp=1", i, cap_seg[i], cap_dp[i], exp[i*7 +: 7]);
      end
    end
  endtask

  // Drive one source value and check the whole display
  task automatic test_value(input string name, input logic s, input logic [31:0] a,
                            input logic [31:0] b, input logic [55:0] exp, input logic [7:0] exp_dp);
    int n;
    sel = s; val_a = a; val_b = b;
    settle(n);
    checks++;
    if (n != EXP_BUSY) begin failures++; $display("FAIL %s busy_cycles got=%0d exp=%0d", name, n, EXP_BUSY); end
    capture_scan;
    checks++;
    if (cap_bad_an != 0 || cap_busy != 0) begin
      failures++;
      $display("FAIL %s scan_onehot/idle bad_an=%0d busy=%0d exp 0/0", name, cap_bad_an, cap_busy);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (cap_seg[i] !== exp[i*7 +: 7] || cap_dp[i] !== exp_dp[i]) begin
        failures++;
        $display("FAIL %s digit %0d seg=%h dp=%b exp seg=%h dp=%b", name, i, cap_seg[i], cap_dp[i], exp[i*7 +: 7], exp_dp[i]);
      end
    end
  endtask

  task automatic test_err;
    logic [55:0] exp_norm, exp_err;
    int n, k;
    exp_norm = BCD ? {BL, BL, BL, BL, BL, S1, S2, S0} : {BL, BL, BL, BL, BL, BL, S7, S8};
    exp_err  = {BL, BL, BL, BL, BL, SE, SR, SR};
    err = 1'b1; sel = 1'b0; val_a = 32'd120;
    settle(n);
    checks++;
    if (n != EXP_BUSY) begin failures++; $display("FAIL err_accept busy_cycles got=%0d exp=%0d", n, EXP_BUSY); end
    capture_scan;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (cap_seg[i] !== exp_err[i*7 +: 7] || cap_dp[i] !== 1'b1) begin
        failures++;
        $display("FAIL err_scan digit %0d seg=%h dp=%b exp seg=%h dp=1", i, cap_seg[i], cap_dp[i], exp_err[i*7 +: 7]);
      end
    end
    err = 1'b0;
    @(negedge clk);
    k = -1;
    for (int i = 0; i < 8; i++) if (an[i] == 1'b0) k = i;
    checks++;
    if (k < 0) begin
      failures++;
      $display("FAIL err_release an got=%h exp one-hot", an);
    end else if (seg !== exp_norm[k*7 +: 7]) begin
      failures++;
      $display("FAIL err_release digit %0d seg got=%h exp=%h", k, seg, exp_norm[k*7 +: 7]);
    end
    capture_scan;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (cap_seg[i] !== exp_norm[i*7 +: 7]) begin
        failures++;
        $display("FAIL err_after digit %0d seg=%h exp=%h", i, cap_seg[i], exp_norm[i*7 +: 7]);
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [55:0] exp;
    int n;
    exp = BCD ? {BL, BL, BL, BL, BL, S7, S2, S0} : {BL, BL, BL, BL, BL, S2, SD, S0};
    sel = 1'b0; val_a = 32'd5;
    n = 0;
    for (int c = 0; c < 100 && n < 10; c++) begin
      @(negedge clk);
      if (!BCD || busy === 1'b1) n++;
    end
    val_a = 32'd720;
    repeat (10) @(negedge clk);
    checks++;
    if (busy !== BCD) begin failures++; $display("FAIL midconv_busy got=%b exp=%b", busy, BCD); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (an !== 8'hFF) begin failures++; $display("FAIL midrst_an got=%h exp=FF", an); end
    checks++; if (seg !== 7'h7F) begin failures++; $display("FAIL midrst_seg got=%h exp=7F", seg); end
    checks++; if (dp !== 1'b1) begin failures++; $display("FAIL midrst_dp got=%b exp=1", dp); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (an !== 8'hFE || seg !== S0) begin
      failures++;
      $display("FAIL midrst_first an=%h seg=%h exp an=FE seg=%h", an, seg, S0);
    end
    n = (busy === 1'b1) ? 1 : 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (busy === 1'b1) n++;
      else break;
    end
    checks++;
    if (n != EXP_BUSY) begin failures++; $display("FAIL midrst_conv busy_cycles got=%0d exp=%0d", n, EXP_BUSY); end
    @(negedge clk);
    capture_scan;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (cap_seg[i] !== exp[i*7 +: 7] || cap_dp[i] !== 1'b1) begin
        failures++;
        $display("FAIL midrst_scan digit %0d seg=%h dp=%b exp seg=%h dp=1", i, cap_seg[i], cap_dp[i], exp[i*7 +: 7]);
      end
    end
  endtask

  initial begin
    test_reset;
    test_value("sel_b", 1'b1, 32'd12345678, 32'h00C0FFEE,
               BCD ? {S1, S2, S6, S4, S8, S4, S3, S0} : {BL, BL, SC, S0, SF, SF, SE, SE}, 8'hFF);
    test_value("sel_a", 1'b0, 32'd12345678, 32'h00C0FFEE,
               BCD ? {S1, S2, S3, S4, S5, S6, S7, S8} : {BL, BL, SB, SC, S6, S1, S4, SE}, 8'hFF);
    test_value("overflow", 1'b0, 32'd3628800000, 32'h00C0FFEE,
               BCD ? {S2, S8, S8, S0, S0, S0, S0, S0} : {SD, S8, S4, SB, S1, S8, S0, S0},
               BCD ? 8'h7F : 8'hFF);
    test_value("zero", 1'b0, 32'd0, 32'h00C0FFEE, {BL, BL, BL, BL, BL, BL, BL, S0}, 8'hFF);
    test_err;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
